ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder_pkg.sv | 30 +++
 rtl/ps2_key_decoder_frame_rx.sv | 119 +++++++++++
 rtl/ps2_key_decoder.sv | 98 +++++++++
 tb/tb_ps2_key_decoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Purpose : Shared definitions for the PS/2 keyboard decoder: frame FSM
//           state encoding, protocol prefix bytes and the set of keyboard
//           status bytes that carry no key information.
// Ports   : none (package).
package ps2_key_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } frame_state_e;

   localparam logic [7:0] PS2_EXT = 8'hE0;   // extended-key prefix
   localparam logic [7:0] PS2_BRK = 8'hF0;   // key-release prefix

   // Status/handshake bytes a keyboard may send outside any key sequence.
   localparam logic [7:0] PS2_IGN_ERR0 = 8'h00;
   localparam logic [7:0] PS2_IGN_BAT  = 8'hAA;
   localparam logic [7:0] PS2_IGN_ECHO = 8'hEE;
   localparam logic [7:0] PS2_IGN_ACK  = 8'hFA;
   localparam logic [7:0] PS2_IGN_RSND = 8'hFE;
   localparam logic [7:0] PS2_IGN_ERR1 = 8'hFF;

   function automatic logic is_ignored_byte(input logic [7:0] b);
      return (b == PS2_IGN_ERR0) || (b == PS2_IGN_BAT)  || (b == PS2_IGN_ECHO) ||
             (b == PS2_IGN_ACK)  || (b == PS2_IGN_RSND) || (b == PS2_IGN_ERR1);
   endfunction

endpackage

// File: rtl/ps2_key_decoder_frame_rx.sv
// Purpose : PS/2 frame receiver. Synchronises the raw keyboard lines,
//           detects falling edges of the keyboard clock, assembles one
//           11-bit frame (start, 8 data LSB first, odd parity, stop) and
//           guards partial frames with a watchdog.
// Ports   : clk_i        system clock
//           rst_ni       synchronous active-low reset
//           ps2_clk_i    raw keyboard clock (asynchronous)
//           ps2_data_i   raw keyboard data (asynchronous)
//           byte_o       received data byte (valid with byte_valid_o)
//           byte_valid_o one-cycle pulse: good frame completed this cycle
//           abort_o      one-cycle pulse: frame rejected or timed out
module ps2_frame_rx
   import ps2_key_decoder_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       abort_o
);

   localparam int unsigned   WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic            ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
   logic            ps2_data_meta_q, ps2_data_sync_q;
   frame_state_e    state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            parity_ok_q, parity_ok_d;
   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            fall;
   logic            sample;

   // Synchronisers idle at the released line level so reset never fakes an edge.
   // NOTE: every clocked assignment uses <= so all flops see the same pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ps2_clk_meta_q  <= 1'b1;
         ps2_clk_sync_q  <= 1'b1;
         ps2_clk_prev_q  <= 1'b1;
         ps2_data_meta_q <= 1'b1;
         ps2_data_sync_q <= 1'b1;
      end else begin
         ps2_clk_meta_q  <= ps2_clk_i;
         ps2_clk_sync_q  <= ps2_clk_meta_q;
         ps2_clk_prev_q  <= ps2_clk_sync_q;
         ps2_data_meta_q <= ps2_data_i;
         ps2_data_sync_q <= ps2_data_meta_q;
      end
   end

   assign fall   = ps2_clk_prev_q & ~ps2_clk_sync_q;
   assign sample = ps2_data_sync_q;
   assign byte_o = shift_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         parity_ok_q <= 1'b0;
         wdog_q      <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         parity_ok_q <= parity_ok_d;
         wdog_q      <= wdog_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      parity_ok_d  = parity_ok_q;
      byte_valid_o = 1'b0;
      abort_o      = 1'b0;
      // Saturate so a long idle line never wraps into a false timeout.
      wdog_d       = (wdog_q == WD_LAST) ? wdog_q : wdog_q + 1'b1;

      if (fall) begin
         wdog_d = '0;
         unique case (state_q)
            ST_IDLE: begin
               if (!sample) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end
            end
            ST_DATA: begin
               shift_d   = {sample, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;            // wraps 7 -> 0
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               parity_ok_d = ^{shift_q, sample};          // odd parity -> 1
               state_d     = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (sample && parity_ok_q) byte_valid_o = 1'b1;
               else                       abort_o      = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if ((state_q != ST_IDLE) && (wdog_q == WD_LAST)) begin
         state_d = ST_IDLE;
         abort_o = 1'b1;
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// Purpose : PS/2 keyboard key-state tracker. Turns received scancode bytes
//           into a 512-entry held-key map indexed by {ext, scancode}.
// Ports   : clk          system clock
//           rst          synchronous active-low reset
//           ps2_clk      raw keyboard clock line
//           ps2_data     raw keyboard data line
//           key_down     bit i set while key index i is held
//           last_change  index of the most recent make or break
//           key_valid    one-cycle pulse when last_change is updated
module ps2_key_decoder
   import ps2_key_decoder_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   output logic [511:0] key_down,
   output logic [8:0]   last_change,
   output logic         key_valid
);

   logic [7:0]   rx_byte;
   logic         rx_valid;
   logic         rx_abort;

   logic         ext_q, ext_d;
   logic         brk_q, brk_d;
   logic [511:0] key_down_q, key_down_d;
   logic [8:0]   last_change_q, last_change_d;
   logic         key_valid_q, key_valid_d;
   logic [8:0]   idx;

   ps2_frame_rx #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_frame_rx (
      .clk_i        (clk),
      .rst_ni       (rst),
      .ps2_clk_i    (ps2_clk),
      .ps2_data_i   (ps2_data),
      .byte_o       (rx_byte),
      .byte_valid_o (rx_valid),
      .abort_o      (rx_abort)
   );

   assign idx = {ext_q, rx_byte};

   always_comb begin
      ext_d         = ext_q;
      brk_d         = brk_q;
      key_down_d    = key_down_q;
      last_change_d = last_change_q;
      key_valid_d   = 1'b0;

      if (rx_abort) begin
         // A damaged or stalled frame may have been part of a sequence.
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (rx_valid) begin
         if (rx_byte == PS2_EXT) begin
            ext_d = 1'b1;
         end else if (rx_byte == PS2_BRK) begin
            brk_d = 1'b1;
         end else if (!ext_q && !brk_q && is_ignored_byte(rx_byte)) begin
            // keyboard status byte: no key event
         end else begin
            key_down_d[idx] = ~brk_q;
            last_change_d   = idx;
            key_valid_d     = 1'b1;
            ext_d           = 1'b0;
            brk_d           = 1'b0;
         end
      end
   end

   // NOTE: the key map is plain flops, not RAM, so it can and must clear on reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ext_q         <= 1'b0;
         brk_q         <= 1'b0;
         key_down_q    <= '0;
         last_change_q <= '0;
         key_valid_q   <= 1'b0;
      end else begin
         ext_q         <= ext_d;
         brk_q         <= brk_d;
         key_down_q    <= key_down_d;
         last_change_q <= last_change_d;
         key_valid_q   <= key_valid_d;
      end
   end

   assign key_down    = key_down_q;
   assign last_change = last_change_q;
   assign key_valid   = key_valid_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Purpose : Self-checking bench for ps2_key_decoder. Drives PS/2 frames,
//           predicts key events with a byte-level model and checks each
//           key_valid pulse against a queue of expected events.
module tb_ps2_key_decoder;

   localparam int unsigned TO  = 300;
   localparam int          GAP = 20;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         ps2_clk = 1'b1;
   logic         ps2_data = 1'b1;
   logic [511:0] key_down;
   logic [8:0]   last_change;
   logic         key_valid;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [8:0]   idx;
      logic [511:0] kd;
   } exp_t;

   exp_t         exp_q[$];
   logic         m_ext = 1'b0;
   logic         m_brk = 1'b0;
   logic [511:0] m_kd  = '0;

   ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .key_down    (key_down),
      .last_change (last_change),
      .key_valid   (key_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: interpret one received byte at the protocol level.
   task automatic model_byte(input logic [7:0] b, input bit good);
      exp_t e;
      if (!good) begin
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (!m_ext && !m_brk &&
                   (b == 8'h00 || b == 8'hAA || b == 8'hEE ||
                    b == 8'hFA || b == 8'hFE || b == 8'hFF)) begin
         // status byte, no event
      end else begin
         e.idx        = {m_ext, b};
         m_kd[e.idx]  = !m_brk;
         e.kd         = m_kd;
         exp_q.push_back(e);
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      repeat (4) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (8) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par);
      logic par;
      model_byte(b, !bad_par);
      par = (~^b) ^ bad_par;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(par);
      send_bit(1'b1);
      ps2_data = 1'b1;
      repeat (GAP) @(posedge clk);
   endtask

   // Monitor: every pulse must match the oldest predicted event.
   always @(negedge clk) begin
      if (rst && key_valid) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pulse actual=%0h required=none", last_change);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pulse_last_change", 512'(last_change), 512'(e.idx));
            check("pulse_key_down", key_down, e.kd);
         end
      end
   end

   task automatic check_quiet(input string name);
      @(negedge clk);
      check({name, "_pending"}, 512'(exp_q.size()), 512'd0);
      check({name, "_key_down"}, key_down, m_kd);
   endtask

   logic [7:0] pool [8] = '{8'h1C, 8'h1B, 8'h29, 8'h75, 8'h5A, 8'h12, 8'h6B, 8'h74};
   logic [7:0] ign  [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

   initial begin
      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_key_down", key_down, 512'd0);
      check("rst_last_change", 512'(last_change), 512'd0);
      check("rst_key_valid", 512'(key_valid), 512'd0);
      @(posedge clk);
      rst = 1'b1;
      repeat (5) @(posedge clk);

      // Make 0x1C
      send_frame(8'h1C, 1'b0);
      check_quiet("make_1c");
      check("make_1c_bit", 512'(key_down[28]), 512'd1);
      check("make_1c_lc", 512'(last_change), 512'h01C);

      // Break 0x1C
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b0);
      check_quiet("brk_1c");
      check("brk_1c_bit", 512'(key_down[28]), 512'd0);
      check("brk_1c_lc", 512'(last_change), 512'h01C);

      // Extended make / break
      send_frame(8'hE0, 1'b0);
      send_frame(8'h75, 1'b0);
      check("ext_make_175", 512'(key_down[9'h175]), 512'd1);
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      check_quiet("ext_brk");
      check("ext_brk_175", 512'(key_down[9'h175]), 512'd0);
      check("ext_brk_075", 512'(key_down[9'h075]), 512'd0);

      // Bad parity then good frame
      send_frame(8'h1C, 1'b1);
      send_frame(8'h1B, 1'b0);
      check_quiet("bad_par");
      check("bad_par_27", 512'(key_down[27]), 512'd1);
      check("bad_par_28", 512'(key_down[28]), 512'd0);

      // Prefix, partial frame, timeout, then good frame (prefix must be lost)
      send_frame(8'hE0, 1'b0);
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      model_byte(8'h00, 1'b0);
      ps2_data = 1'b1;
      repeat (TO + 10) @(posedge clk);
      send_frame(8'h29, 1'b0);
      check_quiet("timeout");
      check("timeout_lc", 512'(last_change), 512'h029);

      // Reset mid-frame while 0x1C is held
      send_frame(8'h1C, 1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rst = 1'b0;
      m_kd  = '0;
      m_ext = 1'b0;
      m_brk = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_key_down", key_down, 512'd0);
      check("midrst_last_change", 512'(last_change), 512'd0);
      check("midrst_key_valid", 512'(key_valid), 512'd0);
      rst = 1'b1;
      ps2_data = 1'b1;
      repeat (GAP) @(posedge clk);
      send_frame(8'h1C, 1'b0);
      check_quiet("after_rst");
      check("after_rst_28", 512'(key_down[28]), 512'd1);

      // Randomised byte stream, including typematic repeats and status bytes
      for (int n = 0; n < 60; n++) begin
         int r;
         r = $urandom_range(0, 11);
         case (r)
            0:       send_frame(8'hE0, 1'b0);
            1, 2:    send_frame(8'hF0, 1'b0);
            3:       send_frame(8'($urandom), 1'b1);
            4:       send_frame(ign[$urandom_range(0, 5)], 1'b0);
            default: send_frame(pool[$urandom_range(0, 7)], 1'b0);
         endcase
      end
      repeat (50) @(posedge clk);
      check_quiet("random_end");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
